// File: rtl/ext_mem_responder.sv
// ext_mem_responder: word RAM plus IO page (8N1 tx FIFO, cycle counter) on the CPU external memory bus
// Ports: clk; rst (sync, active low); WriteMem/ReadMem strobes; ExternalAddr word address;
// ExternalWriteData in; ExternalReadData out (combinational, 0 when ReadMem=0); TxD serial out; TxBusy.
module ext_mem_responder #(
  parameter int RAM_AW       = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WriteMem,
  input  logic        ReadMem,
  input  logic [15:0] ExternalAddr,
  input  logic [15:0] ExternalWriteData,
  output logic [15:0] ExternalReadData,
  output logic        TxD,
  output logic        TxBusy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0]    count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   ram [2**RAM_AW];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic          io_sel, io_wr, io_rd, empty, full, bit_end, push, pop, push_ok;
  logic [15:0]   status, io_data;
  always_comb begin
    io_sel  = ExternalAddr[15:8] == 8'hFF;
    io_wr   = WriteMem && io_sel;
    io_rd   = ReadMem && io_sel;
    empty   = count_q == 5'd0;
    full    = count_q == 5'(FIFO_DEPTH);
    bit_end = clk_cnt_q == CW'(CLKS_PER_BIT - 1);
    pop     = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
    push    = io_wr && ExternalAddr[7:0] == 8'h00;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    push_ok = push && (!full || pop);
    wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    count_d = count_q + 5'(push_ok) - 5'(pop);
    overrun_d = (push && full && !pop) ? 1'b1 :
                (io_wr && ExternalAddr[7:0] == 8'h01 && ExternalWriteData[3]) ? 1'b0 : overrun_q;
    cyc_d    = (io_wr && ExternalAddr[7:0] == 8'h02) ? 32'd0 : cyc_q + 32'd1;
    // hi half frozen at the lo read so a lo/hi pair is coherent
    shadow_d = (io_rd && ExternalAddr[7:0] == 8'h02) ? cyc_q[31:16] : shadow_q;
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (pop) begin
          state_d = START;
          shift_d = fifo[rd_q];
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        state_d = pop ? START : IDLE;
        shift_d = pop ? fifo[rd_q] : shift_q;
      end
      default: state_d = IDLE;
    endcase
    TxD     = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    TxBusy  = state_q != IDLE;
    status  = {7'd0, count_q, overrun_q, TxBusy, full, empty};
    io_data = ExternalAddr[7:0] == 8'h01 ? status :
              ExternalAddr[7:0] == 8'h02 ? cyc_q[15:0] :
              ExternalAddr[7:0] == 8'h03 ? shadow_q : 16'h0000;
    ExternalReadData = !ReadMem ? 16'h0000 : io_sel ? io_data : ram[ExternalAddr[RAM_AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      cyc_q     <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      cyc_q     <= cyc_d;
      shadow_q  <= shadow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (WriteMem && !io_sel) ram[ExternalAddr[RAM_AW-1:0]] <= ExternalWriteData;
    if (push_ok) fifo[wr_q] <= ExternalWriteData[7:0];
  end
endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: directed bench with a serial-receiver scoreboard for ext_mem_responder
module tb_ext_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WriteMem = 1'b0;
  logic        ReadMem = 1'b0;
  logic [15:0] ExternalAddr = '0;
  logic [15:0] ExternalWriteData = '0;
  logic [15:0] ExternalReadData;
  logic        TxD, TxBusy;
  int          tests = 0;
  int          fails = 0;
  int          n;
  bit          mon_en = 1'b1;
  logic [7:0]  sb [$];
  ext_mem_responder #(.RAM_AW(12), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .WriteMem(WriteMem), .ReadMem(ReadMem),
    .ExternalAddr(ExternalAddr), .ExternalWriteData(ExternalWriteData),
    .ExternalReadData(ExternalReadData), .TxD(TxD), .TxBusy(TxBusy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ReadMem = 1'b0;
    WriteMem = 1'b1;
    ExternalAddr = a;
    ExternalWriteData = d;
    tick;
    WriteMem = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    WriteMem = 1'b0;
    ReadMem = 1'b1;
    ExternalAddr = a;
    #1;
    check(tag, ExternalReadData, exp);
  endtask
  initial begin
    logic [7:0] b;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && rst && TxD === 1'b0) begin
        repeat (2) @(negedge clk);
        check("rx_start", {15'd0, TxD}, 16'h0000);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = TxD;
        end
        repeat (4) @(negedge clk);
        check("rx_stop", {15'd0, TxD}, 16'h0001);
        e = sb.size() > 0 ? {8'h00, sb.pop_front()} : 16'hxxxx;
        check("rx_byte", {8'h00, b}, e);
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;
    repeat (2) tick;
    check("rst_txd", {15'd0, TxD}, 16'h0001);
    check("rst_busy", {15'd0, TxBusy}, 16'h0000);
    rdchk("rst_status", 16'hFF01, 16'h0001);
    rdchk("rst_cyclo", 16'hFF02, 16'h0000);
    rdchk("rst_cychi", 16'hFF03, 16'h0000);
    rst = 1'b1;
    wr(16'h0010, 16'hBEEF);
    rdchk("ram_rd", 16'h0010, 16'hBEEF);
    rdchk("ram_alias", 16'h1010, 16'hBEEF);
    ReadMem = 1'b0;
    #1;
    check("ram_noread", ExternalReadData, 16'h0000);
    WriteMem = 1'b1;
    ReadMem = 1'b1;
    ExternalAddr = 16'h0010;
    ExternalWriteData = 16'h1234;
    #1;
    check("ram_rw_old", ExternalReadData, 16'hBEEF);
    tick;
    WriteMem = 1'b0;
    #1;
    check("ram_rw_new", ExternalReadData, 16'h1234);
    rdchk("io_txdata_rd", 16'hFF00, 16'h0000);
    wr(16'hFF05, 16'h5555);
    rdchk("io_unlisted", 16'hFF05, 16'h0000);
    sb.push_back(a5);
    wr(16'hFF00, 16'h00A5);
    check("tx_latency", {15'd0, TxD}, 16'h0001);
    tick;
    for (int k = 0; k < 40; k++) begin
      check("tx_bit", {15'd0, TxD}, {15'd0, k < 4 ? 1'b0 : k >= 36 ? 1'b1 : a5[k/4-1]});
      check("tx_busy", {15'd0, TxBusy}, 16'h0001);
      tick;
    end
    check("tx_done_busy", {15'd0, TxBusy}, 16'h0000);
    check("tx_done_txd", {15'd0, TxD}, 16'h0001);
    repeat (3) tick;
    sb.push_back(8'h01);
    sb.push_back(8'h02);
    wr(16'hFF00, 16'h0001);
    wr(16'hFF00, 16'h0002);
    rdchk("b2b_status1", 16'hFF01, 16'h0014);
    repeat (40) tick;
    rdchk("b2b_status0", 16'hFF01, 16'h0005);
    n = 40;
    while (TxBusy && n < 300) begin
      n++;
      tick;
    end
    check("b2b_busy_cycles", 16'(n), 16'd80);
    repeat (3) tick;
    sb.push_back(8'h11);
    wr(16'hFF00, 16'h0011);
    tick;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) sb.push_back(8'(8'h20 + k));
      wr(16'hFF00, 16'(16'h0020 + k));
    end
    rdchk("ovr_status", 16'hFF01, 16'h004E);
    wr(16'hFF01, 16'h0008);
    rdchk("ovr_clear", 16'hFF01, 16'h0046);
    n = 0;
    while (TxBusy && n < 400) begin
      n++;
      tick;
    end
    check("ovr_drain_busy", {15'd0, TxBusy}, 16'h0000);
    repeat (3) tick;
    check("ovr_sb_empty", 16'(sb.size()), 16'd0);
    rdchk("ovr_status_end", 16'hFF01, 16'h0001);
    wr(16'hFF02, 16'hFFFF);
    repeat (100) tick;
    rdchk("cyc_100", 16'hFF02, 16'h0064);
    wr(16'hFF02, 16'h0000);
    repeat (65535) tick;
    rdchk("cyc_ffff", 16'hFF02, 16'hFFFF);
    tick;
    rdchk("cyc_hi0", 16'hFF03, 16'h0000);
    rdchk("cyc_wrap_lo", 16'hFF02, 16'h0000);
    tick;
    rdchk("cyc_hi1", 16'hFF03, 16'h0001);
    mon_en = 1'b0;
    wr(16'hFF00, 16'h0033);
    wr(16'hFF00, 16'h0044);
    wr(16'hFF00, 16'h0055);
    repeat (10) tick;
    rdchk("mid_status", 16'hFF01, 16'h0024);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("mid_rst_txd", {15'd0, TxD}, 16'h0001);
    check("mid_rst_busy", {15'd0, TxBusy}, 16'h0000);
    rdchk("mid_rst_status", 16'hFF01, 16'h0001);
    repeat (50) tick;
    check("mid_rst_flushed", {15'd0, TxBusy}, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
